// File: rtl/pc_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_unit_pkg
//  Description : Shared definitions for the program-counter unit: next-PC
//                mode encodings and default widths / vectors.
//  Revision    : 1.0  initial release
// ============================================================================
package pc_unit_pkg;

    // Default datapath geometry
    localparam int PC_WIDTH     = 32;
    localparam int PC_IMM_W     = 16;
    localparam int PC_STEP      = 4;
    localparam int PC_RAS_DEPTH = 4;
    localparam int PC_RESET_VEC = 0;
    localparam int PC_TRAP_VEC  = 32'h80;

    // Next-PC mode encoding; codes 5..7 behave as SEQ
    localparam logic [2:0] MODE_SEQ    = 3'd0;
    localparam logic [2:0] MODE_BRANCH = 3'd1;
    localparam logic [2:0] MODE_JREG   = 3'd2;
    localparam logic [2:0] MODE_CALL   = 3'd3;
    localparam logic [2:0] MODE_RET    = 3'd4;

endpackage
`default_nettype wire

// File: rtl/pc_unit_ras_stack.sv
`default_nettype none
// ============================================================================
//  Module      : ras_stack
//  Description : Circular return-address stack. A push onto a full stack
//                overwrites the oldest entry; a pop from an empty stack is
//                ignored. Both conditions raise a registered one-cycle flag.
//  Ports       : clk, rst_n (sync active-low), push, pop, din -> top, count,
//                ovf (push while full), unf (pop while empty)
//  Revision    : 1.0  initial release
// ============================================================================
module ras_stack #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           top,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       ovf,
    output logic                       unf
);

    localparam int             AW     = $clog2(DEPTH);
    localparam logic [AW:0]    c_full = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_ptr;     // index of the current top entry
    logic [AW:0]      r_count;
    logic             r_ovf;
    logic             r_unf;

    logic             w_full;
    logic             w_empty;
    logic [AW-1:0]    w_ptr_inc;
    logic [AW-1:0]    w_ptr_dec;

    assign w_full    = (r_count == c_full);
    assign w_empty   = (r_count == '0);
    assign w_ptr_inc = r_ptr + AW'(1);
    assign w_ptr_dec = r_ptr - AW'(1);

    // The pointer wraps naturally, so a push while full lands on the
    // oldest slot and the most recent DEPTH addresses survive.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_ptr   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_ovf <= push && w_full;
            r_unf <= !push && pop && w_empty;
            if (push) begin
                r_ptr            <= w_ptr_inc;
                r_mem[w_ptr_inc] <= din;
                if (!w_full) begin
                    r_count <= r_count + (AW+1)'(1);
                end
            end else if (pop && !w_empty) begin
                r_ptr   <= w_ptr_dec;
                r_count <= r_count - (AW+1)'(1);
            end
        end
    end

    assign top   = r_mem[r_ptr];
    assign count = r_count;
    assign ovf   = r_ovf;
    assign unf   = r_unf;

endmodule
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pc_unit
//  Description : Program counter with sequential, conditional relative
//                branch, register jump, call and return modes, a circular
//                return-address stack, stall and misaligned-target trap.
//  Ports       : clk, rst_n (sync active-low), stall, mode[2:0], cond,
//                imm[IMM_W], din[WIDTH] -> pc (registered), pc_next (comb),
//                ras_count, ras_ovf / ras_unf / misalign (one-cycle pulses)
//  Revision    : 1.0  initial release
// ============================================================================
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int WIDTH     = PC_WIDTH,
    parameter int IMM_W     = PC_IMM_W,
    parameter int RESET_VEC = PC_RESET_VEC,
    parameter int TRAP_VEC  = PC_TRAP_VEC,
    parameter int RAS_DEPTH = PC_RAS_DEPTH,
    parameter int STEP      = PC_STEP
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          stall,
    input  logic [2:0]                    mode,
    input  logic                          cond,
    input  logic [IMM_W-1:0]              imm,
    input  logic [WIDTH-1:0]              din,
    output logic [WIDTH-1:0]              pc,
    output logic [WIDTH-1:0]              pc_next,
    output logic [$clog2(RAS_DEPTH):0]    ras_count,
    output logic                          ras_ovf,
    output logic                          ras_unf,
    output logic                          misalign
);

    localparam logic [WIDTH-1:0] c_reset_vec = WIDTH'(RESET_VEC);
    localparam logic [WIDTH-1:0] c_trap_vec  = WIDTH'(TRAP_VEC);
    localparam logic [WIDTH-1:0] c_step      = WIDTH'(STEP);

    logic [WIDTH-1:0] r_pc;
    logic             r_misalign;

    logic [WIDTH-1:0] w_seq;
    logic [WIDTH-1:0] w_simm;
    logic [WIDTH-1:0] w_target;
    logic [WIDTH-1:0] w_ras_top;
    logic             w_check;
    logic             w_misalign;
    logic             w_push;
    logic             w_pop;
    logic             w_ras_empty;

    assign w_seq       = r_pc + c_step;
    // Word offset: sign-extend first, then scale to bytes
    assign w_simm      = WIDTH'($signed(imm)) << 2;
    assign w_ras_empty = (ras_count == '0);

    always_comb begin
        w_target = w_seq;
        w_check  = 1'b0;
        w_push   = 1'b0;
        w_pop    = 1'b0;
        case (mode)
            MODE_BRANCH: begin
                if (cond) begin
                    w_target = w_seq + w_simm;
                end
            end
            MODE_JREG: begin
                w_target = din;
                w_check  = 1'b1;
            end
            MODE_CALL: begin
                w_target = din;
                w_check  = 1'b1;
                w_push   = 1'b1;
            end
            MODE_RET: begin
                // The pop request is still issued on an empty stack so the
                // stack itself reports the underflow; the PC falls through.
                w_pop = 1'b1;
                if (!w_ras_empty) begin
                    w_target = w_ras_top;
                    w_check  = 1'b1;
                end
            end
            default: begin
                w_target = w_seq;
            end
        endcase
    end

    assign w_misalign = w_check && (w_target[1:0] != 2'b00);
    assign pc_next    = w_misalign ? c_trap_vec : w_target;

    ras_stack #(
        .DEPTH (RAS_DEPTH),
        .WIDTH (WIDTH)
    ) u_ras (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push && !stall),
        .pop   (w_pop && !stall),
        .din   (w_seq),
        .top   (w_ras_top),
        .count (ras_count),
        .ovf   (ras_ovf),
        .unf   (ras_unf)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc       <= c_reset_vec;
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= !stall && w_misalign;
            if (!stall) begin
                r_pc <= pc_next;
            end
        end
    end

    assign pc       = r_pc;
    assign misalign = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_unit
//  Description : Scoreboard bench for pc_unit with a queue-based reference
//                model of the PC and the return-address stack.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pc_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic [2:0]  mode;
    logic        cond;
    logic [15:0] imm;
    logic [31:0] din;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [2:0]  ras_count;
    logic        ras_ovf;
    logic        ras_unf;
    logic        misalign;

    pc_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall     (stall),
        .mode      (mode),
        .cond      (cond),
        .imm       (imm),
        .din       (din),
        .pc        (pc),
        .pc_next   (pc_next),
        .ras_count (ras_count),
        .ras_ovf   (ras_ovf),
        .ras_unf   (ras_unf),
        .misalign  (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        int          cnt;
        logic        ovf;
        logic        unf;
        logic        mis;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_ras[$];
    logic [31:0] m_pc;
    bit          m_known = 0;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
        end
    endtask

    // Apply one cycle of stimulus and predict the state after the next edge.
    task automatic drive(input logic r, input logic s, input logic [2:0] m,
                         input logic c, input logic [15:0] im, input logic [31:0] d);
        exp_t        e;
        logic [31:0] seq, tgt, nxt;
        logic        chk, mis, ovf, unf;
        bit          was_known;
        @(negedge clk);
        rst_n = r; stall = s; mode = m; cond = c; imm = im; din = d;
        was_known = m_known;
        seq = m_pc + 32'd4;
        tgt = seq; chk = 0; ovf = 0; unf = 0;
        case (m)
            3'd1: if (c) tgt = seq + ({{16{im[15]}}, im} << 2);
            3'd2: begin tgt = d; chk = 1; end
            3'd3: begin tgt = d; chk = 1; end
            3'd4: if (m_ras.size() > 0) begin tgt = m_ras[$]; chk = 1; end
            default: ;
        endcase
        mis = chk && (tgt[1:0] != 2'b00);
        nxt = mis ? 32'h80 : tgt;
        if (!r) begin
            m_pc = 32'h0;
            m_ras.delete();
            mis = 0;
            m_known = 1;
        end else if (s) begin
            mis = 0;
        end else begin
            if (m == 3'd3) begin
                m_ras.push_back(seq);
                if (m_ras.size() > 4) begin
                    void'(m_ras.pop_front());
                    ovf = 1;
                end
            end
            if (m == 3'd4) begin
                if (m_ras.size() > 0) void'(m_ras.pop_back());
                else unf = 1;
            end
            m_pc = nxt;
        end
        e.pc = m_pc; e.cnt = m_ras.size(); e.ovf = ovf; e.unf = unf; e.mis = mis;
        exp_q.push_back(e);
        #1;
        if (was_known) check("pc_next", pc_next, nxt);
    endtask

    // Monitor: the DUT presents a new state after every edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pc", pc, e.pc);
                check("ras_count", 32'(ras_count), 32'(e.cnt));
                check("ras_ovf", 32'(ras_ovf), 32'(e.ovf));
                check("ras_unf", 32'(ras_unf), 32'(e.unf));
                check("misalign", 32'(misalign), 32'(e.mis));
            end
        end
    end

    initial begin : stimulus
        logic [31:0] rd;
        rst_n = 1'b1; stall = 1'b0; mode = 3'd0; cond = 1'b0; imm = '0; din = '0;
        // Reset held across a CALL request
        drive(0, 0, 3'd3, 0, 16'h0, 32'h40);
        drive(0, 0, 3'd3, 0, 16'h0, 32'h40);
        repeat (4) drive(1, 0, 3'd0, 0, 16'h0, 32'h0);           // 4, 8, 12, 0x10
        drive(1, 0, 3'd1, 1, 16'h0005, 32'h0);                    // 0x28
        drive(1, 0, 3'd1, 1, 16'hFFFF, 32'h0);                    // 0x28
        drive(1, 0, 3'd1, 0, 16'hFFFF, 32'h0);                    // 0x2C
        drive(1, 0, 3'd3, 0, 16'h0, 32'h100);                     // CALL
        drive(1, 0, 3'd0, 0, 16'h0, 32'h0);
        drive(1, 0, 3'd4, 0, 16'h0, 32'h0);                       // 0x30
        drive(1, 0, 3'd4, 0, 16'h0, 32'h0);                       // 0x34, underflow
        // Nested calls overflowing a 4-deep stack
        drive(0, 0, 3'd0, 0, 16'h0, 32'h0);
        for (int i = 1; i <= 5; i++) drive(1, 0, 3'd3, 0, 16'h0, 32'(i) << 8);
        for (int i = 0; i < 5; i++) drive(1, 0, 3'd4, 0, 16'h0, 32'h0);
        // Misaligned targets
        drive(1, 0, 3'd2, 0, 16'h0, 32'h202);
        drive(1, 0, 3'd3, 0, 16'h0, 32'h3);
        // Stall holds everything, then the jump lands
        repeat (3) drive(1, 1, 3'd2, 0, 16'h0, 32'h500);
        drive(1, 0, 3'd2, 0, 16'h0, 32'h500);
        // Silent wrap of the sequential increment
        drive(1, 0, 3'd2, 0, 16'h0, 32'hFFFF_FFFC);
        drive(1, 0, 3'd0, 0, 16'h0, 32'h0);
        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            rd = $urandom;
            if ($urandom_range(0, 3) != 0) rd[1:0] = 2'b00;
            drive(($urandom_range(0, 49) != 0), ($urandom_range(0, 7) == 0),
                  3'($urandom_range(0, 7)), 1'($urandom), 16'($urandom), rd);
        end
        @(negedge clk);
        stall = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d predictions left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
